// File: rtl/bus_cycle_engine.sv
// bus_cycle_engine: runs one CPU request as little-endian 8-bit T1/T2/T3/TW/T4 bus cycles.
// Define BUS_CYCLE_TIMEOUT_EN to abort a byte cycle after TIMEOUT_CYC ready-low TW cycles.
module bus_cycle_engine #(
  parameter int ADDR_W      = 20,
  parameter int MAX_BYTES   = 2,
  parameter int MIN_WAIT    = 0,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           req_valid,
  output logic                           req_ready,
  input  logic                           req_write,
  input  logic                           req_io,
  input  logic                           req_sext,
  input  logic [$clog2(MAX_BYTES+1)-1:0] req_bytes,
  input  logic [ADDR_W-1:0]              req_addr,
  input  logic [8*MAX_BYTES-1:0]         req_wdata,
  output logic                           rsp_valid,
  output logic [8*MAX_BYTES-1:0]         rsp_rdata,
  output logic                           rsp_err,
  output logic [ADDR_W-1:0]              addr_o,
  output logic [7:0]                     ad_o,
  output logic                           ad_oe,
  input  logic [7:0]                     ad_i,
  input  logic                           ready,
  output logic                           ale,
  output logic                           rd_n,
  output logic                           wr_n,
  output logic                           den_n,
  output logic                           dtr,
  output logic                           iom
);
  localparam int CNT_W  = $clog2(MAX_BYTES + 1);
  localparam int DATA_W = 8 * MAX_BYTES;
  localparam int K_W    = (MAX_BYTES > 1) ? $clog2(MAX_BYTES) : 1;
  localparam int WAIT_W = (MIN_WAIT > 0) ? $clog2(MIN_WAIT + 1) : 1;

  if (MAX_BYTES < 1 || TIMEOUT_CYC < 1 || ADDR_W < 8) begin : g_bad_cfg
    $error("bus_cycle_engine: MAX_BYTES and TIMEOUT_CYC must be >= 1, ADDR_W >= 8");
  end

  typedef enum logic [2:0] {S_IDLE, S_T1, S_T2, S_T3, S_TW, S_T4} state_t;

  state_t            state_q, state_d;
  logic [K_W-1:0]    k_q, k_d, last_k_q, last_k_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              write_q, write_d, io_q, io_d, sext_q, sext_d;
  logic [ADDR_W-1:0] base_q, base_d, addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d, rdata_q, rdata_d;
  logic              req_ready_q, req_ready_d, rsp_valid_q, rsp_valid_d;
  logic [7:0]        ad_o_q, ad_o_d;
  logic              ad_oe_q, ad_oe_d, ale_q, ale_d, rd_n_q, rd_n_d, wr_n_q, wr_n_d;
  logic              den_n_q, den_n_d, dtr_q, dtr_d, iom_q, iom_d;
  logic [CNT_W-1:0]  req_cnt;
  logic              err_d, strobe;
`ifdef BUS_CYCLE_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
  logic [TO_W-1:0] to_q, to_d;
  logic            err_q;
`endif

  always_comb begin
    if (req_bytes == '0)                    req_cnt = CNT_W'(1);
    else if (req_bytes > CNT_W'(MAX_BYTES)) req_cnt = CNT_W'(MAX_BYTES);
    else                                    req_cnt = req_bytes;
  end

  always_comb begin
    state_d  = state_q;
    k_d      = k_q;
    last_k_d = last_k_q;
    wait_d   = wait_q;
    write_d  = write_q;
    io_d     = io_q;
    sext_d   = sext_q;
    base_d   = base_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
`ifdef BUS_CYCLE_TIMEOUT_EN
    to_d     = '0;
    err_d    = err_q;
`else
    err_d    = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        if (req_valid && req_ready_q) begin
          state_d  = S_T1;
          k_d      = '0;
          last_k_d = K_W'(req_cnt - CNT_W'(1));
          write_d  = req_write;
          io_d     = req_io;
          sext_d   = req_sext && (req_cnt == CNT_W'(1));
          base_d   = req_addr;
          addr_d   = req_addr;
          wdata_d  = req_wdata;
          err_d    = 1'b0;
        end
      end
      S_T1: state_d = S_T2;
      S_T2: begin
        if (MIN_WAIT == 0) begin
          state_d = S_T3;
        end else begin
          state_d = S_TW;
          wait_d  = WAIT_W'(MIN_WAIT);
        end
      end
      S_T3, S_TW: begin
        // Forced waits run out before ready is even looked at.
        if (state_q == S_TW && wait_q != '0) begin
          wait_d = wait_q - WAIT_W'(1);
          if (wait_q == WAIT_W'(1)) state_d = S_T3;
        end else if (ready) begin
          state_d = S_T4;
          if (!write_q) begin
            for (int i = 0; i < MAX_BYTES; i++) begin
              if (i == int'(k_q))     rdata_d[8*i +: 8] = ad_i;
              else if (i > int'(k_q)) rdata_d[8*i +: 8] = sext_q ? {8{ad_i[7]}} : 8'h00;
            end
          end
        end else begin
          state_d = S_TW;
`ifdef BUS_CYCLE_TIMEOUT_EN
          if (state_q == S_TW) begin
            to_d = to_q + TO_W'(1);
            if (to_q == TO_W'(TIMEOUT_CYC - 1)) begin
              state_d = S_T4;
              err_d   = 1'b1;
              to_d    = '0;
              if (!write_q) begin
                for (int i = 0; i < MAX_BYTES; i++) begin
                  if (i >= int'(k_q)) rdata_d[8*i +: 8] = 8'hFF;
                end
              end
            end
          end
`endif
        end
      end
      S_T4: begin
        if (k_q != last_k_q && !err_d) begin
          state_d = S_T1;
          k_d     = k_q + K_W'(1);
          addr_d  = base_q + ADDR_W'(k_d);
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Pin values are computed for the state being entered so they come straight off flops.
    strobe      = (state_d == S_T2) || (state_d == S_T3) || (state_d == S_TW);
    req_ready_d = (state_d == S_IDLE);
    rsp_valid_d = (state_d == S_T4) && ((k_d == last_k_d) || err_d);
    ale_d       = (state_d == S_T1);
    rd_n_d      = !(strobe && !write_d);
    wr_n_d      = !(strobe && write_d);
    den_n_d     = !(strobe || state_d == S_T4);
    ad_oe_d     = (state_d == S_T1) || (write_d && state_d != S_IDLE);
    dtr_d       = (state_d == S_T1) ? write_d : dtr_q;
    iom_d       = (state_d == S_T1) ? io_d : iom_q;
    ad_o_d      = ad_o_q;
    if (state_d == S_T1)                     ad_o_d = addr_d[7:0];
    else if (write_d && state_d != S_IDLE)   ad_o_d = wdata_d[8*int'(k_d) +: 8];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      k_q         <= '0;
      last_k_q    <= '0;
      wait_q      <= '0;
      write_q     <= 1'b0;
      io_q        <= 1'b0;
      sext_q      <= 1'b0;
      base_q      <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      req_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      ad_o_q      <= 8'h00;
      ad_oe_q     <= 1'b0;
      ale_q       <= 1'b0;
      rd_n_q      <= 1'b1;
      wr_n_q      <= 1'b1;
      den_n_q     <= 1'b1;
      dtr_q       <= 1'b1;
      iom_q       <= 1'b0;
`ifdef BUS_CYCLE_TIMEOUT_EN
      to_q        <= '0;
      err_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      last_k_q    <= last_k_d;
      wait_q      <= wait_d;
      write_q     <= write_d;
      io_q        <= io_d;
      sext_q      <= sext_d;
      base_q      <= base_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rdata_q     <= rdata_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      ad_o_q      <= ad_o_d;
      ad_oe_q     <= ad_oe_d;
      ale_q       <= ale_d;
      rd_n_q      <= rd_n_d;
      wr_n_q      <= wr_n_d;
      den_n_q     <= den_n_d;
      dtr_q       <= dtr_d;
      iom_q       <= iom_d;
`ifdef BUS_CYCLE_TIMEOUT_EN
      to_q        <= to_d;
      err_q       <= err_d;
`endif
    end
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rdata_q;
`ifdef BUS_CYCLE_TIMEOUT_EN
  assign rsp_err   = err_q;
`else
  assign rsp_err   = 1'b0;
`endif
  assign addr_o    = addr_q;
  assign ad_o      = ad_o_q;
  assign ad_oe     = ad_oe_q;
  assign ale       = ale_q;
  assign rd_n      = rd_n_q;
  assign wr_n      = wr_n_q;
  assign den_n     = den_n_q;
  assign dtr       = dtr_q;
  assign iom       = iom_q;

endmodule

// File: tb/tb_bus_cycle_engine.sv
// Scoreboard bench for bus_cycle_engine: directed requests push expected responses, a monitor pops them.
module tb_bus_cycle_engine;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        req_valid, req_write, req_io, req_sext;
  logic [1:0]  req_bytes;
  logic [19:0] req_addr;
  logic [15:0] req_wdata;
  logic        req_ready, rsp_valid, rsp_err;
  logic [15:0] rsp_rdata;
  logic [19:0] addr_o;
  logic [7:0]  ad_o, ad_i;
  logic        ad_oe, ready, ale, rd_n, wr_n, den_n, dtr, iom;
  logic [19:0] rd_base;
  logic [15:0] rd_pat;

  logic        req_valid2, req_ready2, rsp_valid2, rsp_err2;
  logic [15:0] rsp_rdata2;
  logic [19:0] addr_o2;
  logic [7:0]  ad_o2, ad_i2;
  logic        ad_oe2, ready2, ale2, rd_n2, wr_n2, den_n2, dtr2, iom2;

  // Slave model: byte 0 of the pattern at the start address, byte 1 anywhere else.
  assign ad_i = (addr_o == rd_base) ? rd_pat[7:0] : rd_pat[15:8];

  bus_cycle_engine #(.ADDR_W(20), .MAX_BYTES(2), .MIN_WAIT(0), .TIMEOUT_CYC(4)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_io(req_io), .req_sext(req_sext), .req_bytes(req_bytes), .req_addr(req_addr),
    .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .addr_o(addr_o), .ad_o(ad_o), .ad_oe(ad_oe), .ad_i(ad_i), .ready(ready), .ale(ale),
    .rd_n(rd_n), .wr_n(wr_n), .den_n(den_n), .dtr(dtr), .iom(iom));

  bus_cycle_engine #(.ADDR_W(20), .MAX_BYTES(2), .MIN_WAIT(2), .TIMEOUT_CYC(4)) dut2 (
    .clk(clk), .rst(rst), .req_valid(req_valid2), .req_ready(req_ready2), .req_write(req_write),
    .req_io(req_io), .req_sext(req_sext), .req_bytes(req_bytes), .req_addr(req_addr),
    .req_wdata(req_wdata), .rsp_valid(rsp_valid2), .rsp_rdata(rsp_rdata2), .rsp_err(rsp_err2),
    .addr_o(addr_o2), .ad_o(ad_o2), .ad_oe(ad_oe2), .ad_i(ad_i2), .ready(ready2), .ale(ale2),
    .rd_n(rd_n2), .wr_n(wr_n2), .den_n(den_n2), .dtr(dtr2), .iom(iom2));

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [15:0] rdata;
    logic        err;
    int          lat;
    int          acc;
    string       name;
  } exp_t;
  exp_t sb[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input string name, input logic wr, input logic io, input logic sx,
                       input logic [1:0] nb, input logic [19:0] a, input logic [15:0] wd,
                       input bit push, input logic [15:0] er, input logic ee, input int lat);
    exp_t e;
    int n = 0;
    while (req_ready !== 1'b1 && n < 50) begin tick(); n++; end
    if (req_ready !== 1'b1) begin
      checks++; errors++;
      $display("FAIL %s_accept: req_ready=%b expected 1", name, req_ready);
    end
    req_valid = 1'b1; req_write = wr; req_io = io; req_sext = sx;
    req_bytes = nb; req_addr = a; req_wdata = wd;
    tick();
    req_valid = 1'b0;
    if (push) begin
      e.rdata = er; e.err = ee; e.lat = lat; e.acc = cyc; e.name = name;
      sb.push_back(e);
    end
  endtask

  task automatic drain(input string name);
    int n = 0;
    while ((sb.size() != 0 || req_ready !== 1'b1) && n < 100) begin tick(); n++; end
    if (sb.size() != 0 || req_ready !== 1'b1) begin
      checks++; errors++;
      $display("FAIL %s_drain: outstanding=%0d req_ready=%b expected 0 and 1", name, sb.size(), req_ready);
    end
  endtask

  // Monitor: every completion pulse is matched against the oldest expected response.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (rsp_valid === 1'b1) begin
        if (sb.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_rsp: rsp_valid=1 expected 0 (nothing outstanding)");
        end else begin
          e = sb.pop_front();
          check({e.name, "_rdata"}, 32'(rsp_rdata), 32'(e.rdata));
          check({e.name, "_err"}, 32'(rsp_err), 32'(e.err));
          check({e.name, "_lat"}, cyc - e.acc + 1, e.lat);
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation still running at time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc, n;
    rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_io = 1'b0; req_sext = 1'b0;
    req_bytes = 2'd0; req_addr = '0; req_wdata = '0; ready = 1'b1;
    rd_base = '0; rd_pat = '0; req_valid2 = 1'b0; ad_i2 = 8'hA5; ready2 = 1'b1;
    tick(); tick();
    check("rst_req_ready", req_ready, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rdata", rsp_rdata, 0);
    check("rst_err", rsp_err, 0);
    check("rst_addr", addr_o, 0);
    check("rst_ad_o", ad_o, 0);
    check("rst_pins", {ale, rd_n, wr_n, den_n, dtr, iom, ad_oe}, 7'b0111100);
    rst = 1'b0;

    // 2-byte memory read crossing 0FFFF -> 10000
    rd_base = 20'h0FFFF; rd_pat = 16'h1234;
    issue("rd2", 1'b0, 1'b0, 1'b0, 2'd2, 20'h0FFFF, 16'h0, 1'b1, 16'h1234, 1'b0, 8);
    check("rd2_c1_ale", ale, 1);
    check("rd2_c1_addr", addr_o, 20'h0FFFF);
    check("rd2_c1_ad_o", {ad_oe, ad_o}, 9'h1FF);
    check("rd2_c1_iom_dtr", {iom, dtr}, 2'b00);
    tick();
    check("rd2_c2_pins", {ale, rd_n, wr_n, den_n, ad_oe}, 5'b00100);
    tick(); tick();
    check("rd2_c4_pins", {rd_n, wr_n, den_n}, 3'b110);
    tick();
    check("rd2_c5_ale", ale, 1);
    check("rd2_c5_addr", addr_o, 20'h10000);
    drain("rd2");

    // 2-byte I/O write
    issue("wr2", 1'b1, 1'b1, 1'b0, 2'd2, 20'h00300, 16'hBEEF, 1'b1, 16'h1234, 1'b0, 8);
    check("wr2_c1_dtr_iom", {dtr, iom}, 2'b11);
    tick();
    check("wr2_c2_wr", {wr_n, rd_n, ad_oe, ad_o}, {3'b011, 8'hEF});
    tick(); tick();
    check("wr2_c4_hold", {wr_n, ad_oe, ad_o}, {2'b11, 8'hEF});
    tick(); tick();
    check("wr2_c6_wr", {wr_n, ad_oe, ad_o}, {2'b01, 8'hBE});
    drain("wr2");

    // 1-byte reads at the top of the address space, with and without sign extension
    rd_base = 20'hFFFFF; rd_pat = 16'h559C;
    issue("sx1", 1'b0, 1'b0, 1'b1, 2'd1, 20'hFFFFF, 16'h0, 1'b1, 16'hFF9C, 1'b0, 4);
    check("sx1_c1_dtr", dtr, 0);
    drain("sx1");
    issue("zx1", 1'b0, 1'b0, 1'b0, 2'd1, 20'hFFFFF, 16'h0, 1'b1, 16'h009C, 1'b0, 4);
    drain("zx1");

    // Byte count clamping: 3 -> 2, 0 -> 1
    rd_base = 20'h00400; rd_pat = 16'hC3A7;
    issue("clamp3", 1'b0, 1'b0, 1'b0, 2'd3, 20'h00400, 16'h0, 1'b1, 16'hC3A7, 1'b0, 8);
    drain("clamp3");
    rd_base = 20'h00500; rd_pat = 16'h7E81;
    issue("zero0", 1'b0, 1'b0, 1'b0, 2'd0, 20'h00500, 16'h0, 1'b1, 16'h0081, 1'b0, 4);
    drain("zero0");

    // ready low across three T3/TW samples
    rd_base = 20'h00100; rd_pat = 16'h005A;
    issue("wait3", 1'b0, 1'b0, 1'b0, 2'd1, 20'h00100, 16'h0, 1'b1, 16'h005A, 1'b0, 7);
    ready = 1'b0;
    tick(); tick(); tick(); tick();
    check("wait3_c5_rd", {rd_n, den_n}, 2'b00);
    tick();
    check("wait3_c6_old", rsp_rdata, 16'h0081);
    ready = 1'b1;
    drain("wait3");

    // Second instance with two forced waits
    req_write = 1'b0; req_io = 1'b0; req_sext = 1'b0; req_bytes = 2'd1; req_addr = 20'h00A00;
    n = 0;
    while (req_ready2 !== 1'b1 && n < 50) begin tick(); n++; end
    req_valid2 = 1'b1;
    tick();
    req_valid2 = 1'b0;
    acc = cyc;
    n = 0;
    while (rsp_valid2 !== 1'b1 && n < 30) begin tick(); n++; end
    check("mw2_lat", (rsp_valid2 === 1'b1) ? cyc - acc + 1 : -1, 6);
    check("mw2_rdata", rsp_rdata2, 16'h00A5);

    // Reset in T2 of a 2-byte write
    issue("rstwr", 1'b1, 1'b0, 1'b0, 2'd2, 20'h00600, 16'h1357, 1'b0, 16'h0, 1'b0, 0);
    tick();
    check("rstwr_c2_wr", wr_n, 0);
    rst = 1'b1;
    tick();
    check("rstwr_pins", {rd_n, wr_n, den_n, ad_oe, rsp_valid, req_ready}, 6'b111000);
    rst = 1'b0;
    tick();
    check("rstwr_ready", req_ready, 1);
    check("rstwr_rdata", rsp_rdata, 0);
    tick(); tick();
    rd_base = 20'h00700; rd_pat = 16'hD00D;
    issue("post_rst", 1'b0, 1'b0, 1'b0, 2'd2, 20'h00700, 16'h0, 1'b1, 16'hD00D, 1'b0, 8);
    drain("post_rst");

`ifdef BUS_CYCLE_TIMEOUT_EN
    ready = 1'b0;
    rd_base = 20'h00800; rd_pat = 16'h1122;
    issue("tmo", 1'b0, 1'b0, 1'b0, 2'd2, 20'h00800, 16'h0, 1'b1, 16'hFFFF, 1'b1, 8);
    drain("tmo");
    ready = 1'b1;
    check("tmo_err_held", rsp_err, 1);
    rd_base = 20'h00900; rd_pat = 16'h0011;
    issue("tmo_next", 1'b0, 1'b0, 1'b0, 2'd1, 20'h00900, 16'h0, 1'b1, 16'h0011, 1'b0, 4);
    check("tmo_err_clr", rsp_err, 0);
    drain("tmo_next");
`endif

    tick(); tick(); tick();
    check("sb_empty", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
